// File: rtl/controller_events_pkg.sv
// Shared constants for the game-controller event block: button count, bit map
// and counter widths.
package controller_events_pkg;

  localparam int unsigned NUM_BUTTONS = 12;

  localparam int unsigned BTN_B      = 0;
  localparam int unsigned BTN_Y      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_N      = 4;
  localparam int unsigned BTN_S      = 5;
  localparam int unsigned BTN_W      = 6;
  localparam int unsigned BTN_E      = 7;
  localparam int unsigned BTN_A      = 8;
  localparam int unsigned BTN_X      = 9;
  localparam int unsigned BTN_L      = 10;
  localparam int unsigned BTN_R      = 11;

  localparam int unsigned MISMATCH_W = 3;
  localparam int unsigned HOLD_W     = 8;
  localparam int unsigned TIMEOUT_W  = 17;

endpackage

// File: rtl/controller_events_button_debounce_cell.sv
// One controller button: frame-based debounce, press/release pulses and a
// saturating hold counter. A timeout strobe force-releases the button.
module button_debounce_cell
  import controller_events_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 3,
  parameter int unsigned HOLD_FRAMES     = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_valid,
  input  logic timeout,
  input  logic btn_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic hold
);

  localparam logic [MISMATCH_W-1:0] DEB_MAX  = MISMATCH_W'(DEBOUNCE_FRAMES);
  localparam logic [HOLD_W-1:0]     HOLD_MAX = HOLD_W'(HOLD_FRAMES);

  logic [MISMATCH_W-1:0] mis_q, mis_d, mis_inc;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic pressed_q, pressed_d;
  logic press_pulse_q, press_pulse_d;
  logic release_pulse_q, release_pulse_d;
  logic hold_q, hold_d;

  always_comb begin
    mis_d           = mis_q;
    hold_cnt_d      = hold_cnt_q;
    pressed_d       = pressed_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    mis_inc         = MISMATCH_W'(mis_q + 1'b1);

    if (timeout) begin
      // Lost controller: drop the button, announce the release once.
      release_pulse_d = pressed_q;
      pressed_d       = 1'b0;
      mis_d           = '0;
      hold_cnt_d      = '0;
    end else if (frame_valid) begin
      if ((!btn_n) != pressed_q) begin
        if (mis_inc == DEB_MAX) begin
          pressed_d       = !pressed_q;
          press_pulse_d   = !pressed_q;
          release_pulse_d = pressed_q;
          mis_d           = '0;
        end else begin
          mis_d = mis_inc;
        end
      end else begin
        mis_d = '0;
      end

      if (!pressed_d) begin
        hold_cnt_d = '0;
      end else if (hold_cnt_q != HOLD_MAX) begin
        hold_cnt_d = HOLD_W'(hold_cnt_q + 1'b1);
      end
    end

    hold_d = (hold_cnt_d == HOLD_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mis_q           <= '0;
      hold_cnt_q      <= '0;
      pressed_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      hold_q          <= 1'b0;
    end else begin
      mis_q           <= mis_d;
      hold_cnt_q      <= hold_cnt_d;
      pressed_q       <= pressed_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      hold_q          <= hold_d;
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign hold          = hold_q;

endmodule

// File: rtl/controller_events.sv
// Controller button event generator: per-button debounce cells plus a
// frame-silence watchdog that declares the controller lost.
module controller_events
  import controller_events_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 3,
  parameter int unsigned HOLD_FRAMES     = 30,
  parameter int unsigned TIMEOUT_CYCLES  = 100000
) (
  input  logic                   clk_50,
  input  logic                   reset,
  input  logic                   frame_valid,
  input  logic [NUM_BUTTONS-1:0] buttons_n,
  output logic [NUM_BUTTONS-1:0] pressed,
  output logic [NUM_BUTTONS-1:0] press_pulse,
  output logic [NUM_BUTTONS-1:0] release_pulse,
  output logic [NUM_BUTTONS-1:0] hold,
  output logic                   controller_lost
);

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_MAX = TIMEOUT_W'(TIMEOUT_CYCLES);

  logic [TIMEOUT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic lost_q, lost_d;
  logic timeout_c;

  // Frames reset the silence counter; the expiry edge fires exactly once.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    lost_d     = lost_q;
    timeout_c  = 1'b0;
    if (frame_valid) begin
      idle_cnt_d = '0;
      lost_d     = 1'b0;
    end else if (idle_cnt_q != TIMEOUT_MAX) begin
      idle_cnt_d = TIMEOUT_W'(idle_cnt_q + 1'b1);
      if (idle_cnt_d == TIMEOUT_MAX) begin
        timeout_c = 1'b1;
        lost_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      idle_cnt_q <= '0;
      lost_q     <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      lost_q     <= lost_d;
    end
  end

  assign controller_lost = lost_q;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    button_debounce_cell #(
      .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES),
      .HOLD_FRAMES    (HOLD_FRAMES)
    ) u_cell (
      .clk          (clk_50),
      .reset        (reset),
      .frame_valid  (frame_valid),
      .timeout      (timeout_c),
      .btn_n        (buttons_n[i]),
      .pressed      (pressed[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .hold         (hold[i])
    );
  end

endmodule

// File: tb/tb_controller_events.sv
// Scoreboard bench for controller_events: the driver queues hand-computed
// per-cycle expectations, a monitor pops and compares after each edge.
module tb_controller_events;

  localparam int unsigned TO = 1000;

  logic        clk_50 = 1'b0;
  logic        reset = 1'b1;
  logic        frame_valid = 1'b0;
  logic [11:0] buttons_n = 12'hFFF;
  logic [11:0] pressed, press_pulse, release_pulse, hold;
  logic        controller_lost;

  typedef struct packed {
    logic [11:0] p;
    logic [11:0] pp;
    logic [11:0] rp;
    logic [11:0] h;
    logic        lost;
  } obs_t;

  typedef struct packed {
    logic chk;
    obs_t o;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail = 0;

  always #5 clk_50 = ~clk_50;

  controller_events #(
    .DEBOUNCE_FRAMES(3),
    .HOLD_FRAMES    (30),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_50         (clk_50),
    .reset          (reset),
    .frame_valid    (frame_valid),
    .buttons_n      (buttons_n),
    .pressed        (pressed),
    .press_pulse    (press_pulse),
    .release_pulse  (release_pulse),
    .hold           (hold),
    .controller_lost(controller_lost)
  );

  function automatic obs_t mk(input logic [11:0] p, input logic [11:0] pp,
                              input logic [11:0] rp, input logic [11:0] h,
                              input logic lost);
    obs_t o;
    o.p = p; o.pp = pp; o.rp = rp; o.h = h; o.lost = lost;
    return o;
  endfunction

  // One clock of stimulus; expectation is for outputs after the next edge.
  task automatic cycle(input logic r, input logic fv, input logic [11:0] bn,
                       input logic chk, input obs_t e, input string nm);
    exp_t x;
    @(negedge clk_50);
    reset       = r;
    frame_valid = fv;
    buttons_n   = bn;
    x.chk = chk;
    x.o   = e;
    exp_q.push_back(x);
    name_q.push_back(nm);
  endtask

  task automatic frame(input logic [11:0] bn, input obs_t e, input string nm);
    cycle(1'b0, 1'b1, bn, 1'b1, e, nm);
  endtask

  task automatic idle(input int n, input obs_t e, input string nm);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 12'hFFF, 1'b1, e, nm);
  endtask

  // Monitor: compare DUT outputs just after each rising edge.
  initial begin
    exp_t  e;
    string nm;
    obs_t  got;
    forever begin
      @(posedge clk_50);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (e.chk) begin
          got = mk(pressed, press_pulse, release_pulse, hold, controller_lost);
          n_checks++;
          if (got !== e.o) begin
            n_fail++;
            $display("FAIL %s @%0t: got p=%h pp=%h rp=%h h=%h lost=%b, expected p=%h pp=%h rp=%h h=%h lost=%b",
                     nm, $time, got.p, got.pp, got.rp, got.h, got.lost,
                     e.o.p, e.o.pp, e.o.rp, e.o.h, e.o.lost);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o0;
    o0 = mk(12'h000, 12'h000, 12'h000, 12'h000, 1'b0);

    // Reset, including reset overriding a concurrent frame
    cycle(1'b1, 1'b0, 12'hFFF, 1'b1, o0, "reset_state");
    cycle(1'b1, 1'b1, 12'hFFE, 1'b1, o0, "reset_over_frame");

    // B pressed for three frames
    frame(12'hFFE, o0, "b_f1");
    frame(12'hFFE, o0, "b_f2");
    frame(12'hFFE, mk(12'h001, 12'h001, 12'h000, 12'h000, 1'b0), "b_press");

    // Bounce on B is rejected
    for (int i = 0; i < 10; i++)
      frame((i % 2 == 0) ? 12'hFFF : 12'hFFE, mk(12'h001, 12'h000, 12'h000, 12'h000, 1'b0), "bounce");

    frame(12'hFFF, mk(12'h001, 12'h000, 12'h000, 12'h000, 1'b0), "b_rel_f1");
    frame(12'hFFF, mk(12'h001, 12'h000, 12'h000, 12'h000, 1'b0), "b_rel_f2");
    frame(12'hFFF, mk(12'h000, 12'h000, 12'h001, 12'h000, 1'b0), "b_release");
    idle(1, o0, "b_idle");

    // A held for 33 frames: hold after frame 32, saturates after
    frame(12'hEFF, o0, "a_f1");
    frame(12'hEFF, o0, "a_f2");
    frame(12'hEFF, mk(12'h100, 12'h100, 12'h000, 12'h000, 1'b0), "a_press");
    for (int i = 4; i <= 31; i++)
      frame(12'hEFF, mk(12'h100, 12'h000, 12'h000, 12'h000, 1'b0), "a_pre_hold");
    frame(12'hEFF, mk(12'h100, 12'h000, 12'h000, 12'h100, 1'b0), "a_hold");
    frame(12'hEFF, mk(12'h100, 12'h000, 12'h000, 12'h100, 1'b0), "a_hold_sat");
    frame(12'hFFF, mk(12'h100, 12'h000, 12'h000, 12'h100, 1'b0), "a_rel_f1");
    frame(12'hFFF, mk(12'h100, 12'h000, 12'h000, 12'h100, 1'b0), "a_rel_f2");
    frame(12'hFFF, mk(12'h000, 12'h000, 12'h100, 12'h000, 1'b0), "a_release");
    idle(1, o0, "a_idle");

    // START + L pressed, then frame silence until lost
    frame(12'hBF7, o0, "sl_f1");
    frame(12'hBF7, o0, "sl_f2");
    frame(12'hBF7, mk(12'h408, 12'h408, 12'h000, 12'h000, 1'b0), "sl_press");
    idle(TO - 1, mk(12'h408, 12'h000, 12'h000, 12'h000, 1'b0), "sl_wait");
    idle(1, mk(12'h000, 12'h000, 12'h408, 12'h000, 1'b1), "lost_expiry");
    idle(3, mk(12'h000, 12'h000, 12'h000, 12'h000, 1'b1), "lost_quiet");
    frame(12'hFFF, o0, "lost_clear");

    // Frame arriving in the expiry cycle wins
    idle(TO - 1, o0, "expiry_wait");
    frame(12'hFFF, o0, "frame_at_expiry");
    idle(3, o0, "after_expiry_frame");

    // Reset mid-debounce discards the partial count
    frame(12'hFFE, o0, "md_f1");
    frame(12'hFFE, o0, "md_f2");
    cycle(1'b1, 1'b1, 12'hFFE, 1'b1, o0, "rst_mid");
    frame(12'hFFE, o0, "post_rst_1");
    frame(12'hFFE, o0, "post_rst_2");
    frame(12'hFFE, mk(12'h001, 12'h001, 12'h000, 12'h000, 1'b0), "post_rst_press");
    cycle(1'b1, 1'b0, 12'hFFE, 1'b1, o0, "rst_no_release_pulse");
    cycle(1'b0, 1'b0, 12'hFFF, 1'b1, o0, "final_idle");

    @(posedge clk_50);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/controller_events.md
CONTROLLER_EVENTS -- requirements
Module: controller_events

Interface
REQ-001 Parameter DEBOUNCE_FRAMES, default 3, consecutive differing frames required to accept a button change (legal 1..7).
REQ-002 Parameter HOLD_FRAMES, default 30, frames a button must stay pressed before hold asserts (legal 1..255).
REQ-003 Parameter TIMEOUT_CYCLES, default 100000, clock cycles without a frame before the controller is declared lost.
REQ-004 clk_50  input  1  system clock; one clock, all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 frame_valid  input  1  one-cycle strobe: buttons_n holds a complete, freshly shifted controller frame.
REQ-007 buttons_n  input  12  raw button levels, active-low (0 = pressed); bit order 0 B, 1 Y, 2 SELECT, 3 START, 4 N, 5 S, 6 W, 7 E, 8 A, 9 X, 10 L, 11 R.
REQ-008 pressed  output  12  debounced button state, active-high.
REQ-009 press_pulse  output  12  one-cycle pulse per bit on accepted press.
REQ-010 release_pulse  output  12  one-cycle pulse per bit on accepted release.
REQ-011 hold  output  12  per-bit level: button pressed for at least HOLD_FRAMES accepted frames.
REQ-012 controller_lost  output  1  level: no frame_valid for TIMEOUT_CYCLES cycles.

Function
REQ-013 buttons_n shall be sampled only in cycles with frame_valid=1; other cycles leave all per-button state unchanged.
REQ-014 Each bit shall keep a 3-bit mismatch counter: on a frame where ~buttons_n[i] differs from pressed[i], increment; where equal, clear to 0.
REQ-015 When the incremented mismatch count equals DEBOUNCE_FRAMES, pressed[i] shall toggle and the counter clear to 0, in the same update.
REQ-016 press_pulse[i] / release_pulse[i] shall assert for exactly the one cycle after the frame_valid cycle that caused pressed[i] to rise / fall (latency 1); never both for the same bit.
REQ-017 Each bit shall keep an 8-bit hold counter: clear when pressed[i]=0 after update, increment on each frame with pressed[i]=1 after update, saturate at HOLD_FRAMES.
REQ-018 hold[i] shall equal 1 exactly when hold counter[i] == HOLD_FRAMES; it drops in the same cycle pressed[i] falls.
REQ-019 A 17-bit cycle counter shall clear on frame_valid and otherwise increment, saturating at TIMEOUT_CYCLES.
REQ-020 On the cycle the counter reaches TIMEOUT_CYCLES: controller_lost<=1; pressed, hold, mismatch and hold counters cleared; release_pulse[i] asserted one cycle for every bit pressed at that moment.
REQ-021 While controller_lost=1, no further release pulses; the next frame_valid clears controller_lost and is processed normally per REQ-014..017.
REQ-022 frame_valid in the same cycle the counter would reach TIMEOUT_CYCLES: frame wins, no timeout.
REQ-023 frame_valid asserted on consecutive cycles: each cycle is a separate frame; pulses may occur back-to-back.

Reset
REQ-024 reset=1 clears pressed, press_pulse, release_pulse, hold, controller_lost and all counters on the next edge; no pulses generated by reset.
REQ-025 reset overrides frame_valid and timeout in the same cycle; a reset mid-debounce discards partial mismatch counts.

Structure
REQ-026 Shared package: NUM_BUTTONS=12, named bit-index constants BTN_B..BTN_R per REQ-007.
REQ-027 One sub-module, button_debounce_cell (one bit: mismatch counter, hold counter, pulses), instantiated 12 times; timeout logic stays in controller_events.

Verification
REQ-028 Reset, then frames with buttons_n=12'hFFE (B low) x3 -> pressed=12'h001 after third frame, press_pulse[0] one cycle, no earlier change.
REQ-029 B held, frames alternating 12'hFFE/12'hFFF x10 -> pressed[0] never changes, no pulses (bounce rejected).
REQ-030 A (bit 8) held 32 frames -> press_pulse[8] after frame 3, hold[8]=1 after frame 32 (30 accepted-pressed frames), then 3 release frames -> hold[8] and pressed[8] fall together, one release_pulse[8].
REQ-031 START and L pressed (pressed=12'h408), then no frame_valid for 100000 cycles -> controller_lost=1, release_pulse=12'h408 one cycle, pressed=0; next frame clears controller_lost.
REQ-032 frame_valid in exactly the expiry cycle -> controller_lost stays 0; reset asserted mid-debounce (count 2) -> next 2 mismatching frames do not toggle pressed.
